// File: rtl/isq_issue_sel_if.sv
// isq_issue_sel_if: ISQ-side request bus plus the per-port execute handshake
// of the issue-select stage. The perf counter outputs are present only when
// ISSUE_SEL_PERF_CNT_EN is defined.
interface isq_issue_sel_if #(
    parameter int ISQ_DEPTH = 64,
    parameter int IDX_BITS  = 6,
    parameter int PKT_WIDTH = 66,
    parameter int NUM_PORTS = 4,
    parameter int CNT_WIDTH = 16
);
    // ISQ view: per-entry packet, state bits, port masks and age origin
    logic [ISQ_DEPTH*PKT_WIDTH-1:0] isq_pkt_flat;
    logic [ISQ_DEPTH-1:0]           isq_vld;
    logic [ISQ_DEPTH-1:0]           isq_wat;
    logic [ISQ_DEPTH-1:0]           isq_rdy;
    logic [ISQ_DEPTH*NUM_PORTS-1:0] isq_port_msk_flat;
    logic [IDX_BITS-1:0]            isq_head;
    logic                           flush;

    // Execute view: one registered slot per function-unit port
    logic [NUM_PORTS-1:0]           out_rdy;
    logic [NUM_PORTS-1:0]           out_vld;
    logic [NUM_PORTS*PKT_WIDTH-1:0] out_pkt_flat;
    logic [NUM_PORTS*IDX_BITS-1:0]  out_idx_flat;

    // Entries picked this cycle; the ISQ clears their wait bit at the edge
    logic [ISQ_DEPTH-1:0]           sel_clr_wat;

`ifdef ISSUE_SEL_PERF_CNT_EN
    logic [NUM_PORTS*CNT_WIDTH-1:0] perf_issue_cnt_flat;
    logic [NUM_PORTS*CNT_WIDTH-1:0] perf_stall_cnt_flat;
`endif

    // The entry index must address exactly the ISQ, and counters need a bit
    if (IDX_BITS != $clog2(ISQ_DEPTH) || CNT_WIDTH < 1) begin : g_param_chk
        $error("isq_issue_sel_if: IDX_BITS must equal clog2(ISQ_DEPTH) and CNT_WIDTH must be >= 1");
    end

    // Issue-select stage side
    modport slave (
        input  isq_pkt_flat, isq_vld, isq_wat, isq_rdy, isq_port_msk_flat,
        input  isq_head, flush, out_rdy,
        output out_vld, out_pkt_flat, out_idx_flat, sel_clr_wat
`ifdef ISSUE_SEL_PERF_CNT_EN
        , output perf_issue_cnt_flat, perf_stall_cnt_flat
`endif
    );

    // ISQ / execute side
    modport master (
        output isq_pkt_flat, isq_vld, isq_wat, isq_rdy, isq_port_msk_flat,
        output isq_head, flush, out_rdy,
        input  out_vld, out_pkt_flat, out_idx_flat, sel_clr_wat
`ifdef ISSUE_SEL_PERF_CNT_EN
        , input perf_issue_cnt_flat, perf_stall_cnt_flat
`endif
    );
endinterface

// File: rtl/isq_issue_sel.sv
// isq_issue_sel: age-ordered issue select between the ISQ and register read.
// Each cycle every free port takes the oldest eligible entry (age counted
// from isq_head, wrapping) that a lower port has not already taken; the pick
// is registered into that port's output slot with a valid/ready handshake.
// Optional per-port issue/stall counters: define ISSUE_SEL_PERF_CNT_EN.
module isq_issue_sel #(
    parameter int ISQ_DEPTH = 64,
    parameter int IDX_BITS  = 6,
    parameter int PKT_WIDTH = 66,
    parameter int NUM_PORTS = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    isq_issue_sel_if.slave      sel_bus
);

    if (IDX_BITS != $clog2(ISQ_DEPTH) || CNT_WIDTH < 1) begin : g_param_chk
        $error("isq_issue_sel: IDX_BITS must equal clog2(ISQ_DEPTH) and CNT_WIDTH must be >= 1");
    end

    logic [ISQ_DEPTH-1:0] elig_p0;
    logic [ISQ_DEPTH-1:0] port_elig_p0 [NUM_PORTS];
    logic [PKT_WIDTH-1:0] ent_pkt_p0   [ISQ_DEPTH];
    logic [NUM_PORTS-1:0] port_free_p0;
    logic [NUM_PORTS-1:0] sel_vld_p0;
    logic [IDX_BITS-1:0]  sel_idx_p0   [NUM_PORTS];
    logic [ISQ_DEPTH-1:0] taken_p0;

    logic [NUM_PORTS-1:0] vld_p1;
    logic [PKT_WIDTH-1:0] pkt_p1       [NUM_PORTS];
    logic [IDX_BITS-1:0]  idx_p1       [NUM_PORTS];

    // ---- p0: selection (combinational, same cycle as the ISQ state) ----

    // Entry eligibility, then split per port by the entry's port mask.
    // Reset and flush kill every candidate so nothing is cleared in the ISQ.
    always_comb begin
        elig_p0 = sel_bus.isq_vld & sel_bus.isq_wat & sel_bus.isq_rdy
                & {ISQ_DEPTH{~(sel_bus.flush | rst)}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_elig_p0[p] = '0;
            for (int i = 0; i < ISQ_DEPTH; i++) begin
                port_elig_p0[p][i] = elig_p0[i] & sel_bus.isq_port_msk_flat[i*NUM_PORTS + p];
            end
        end
    end

    // Unpack the flat ISQ packet bus into one word per entry.
    always_comb begin
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            ent_pkt_p0[i] = sel_bus.isq_pkt_flat[i*PKT_WIDTH +: PKT_WIDTH];
        end
    end

    // A slot can accept a new packet when it is empty or drains this cycle.
    assign port_free_p0 = ~vld_p1 | sel_bus.out_rdy;

    // Sequential port service: port 0 first, each port scanning from head
    // in age order and skipping entries already taken by lower ports.
    // A busy port picks nothing and leaves the entries to higher ports.
    always_comb begin
        int                  pos;
        logic [IDX_BITS-1:0] cand;
        taken_p0   = '0;
        sel_vld_p0 = '0;
        pos        = 0;
        cand       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_idx_p0[p] = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_free_p0[p]) begin
                for (int k = 0; k < ISQ_DEPTH; k++) begin
                    pos = int'(sel_bus.isq_head) + k;
                    if (pos >= ISQ_DEPTH) begin
                        pos = pos - ISQ_DEPTH;
                    end
                    cand = IDX_BITS'(pos);
                    if (!sel_vld_p0[p] && port_elig_p0[p][cand] && !taken_p0[cand]) begin
                        sel_vld_p0[p] = 1'b1;
                        sel_idx_p0[p] = cand;
                    end
                end
                if (sel_vld_p0[p]) begin
                    taken_p0[sel_idx_p0[p]] = 1'b1;
                end
            end
        end
    end

    assign sel_bus.sel_clr_wat = taken_p0;

    // ---- p1: registered per-port output slots ----

    // Load on a pick, drain on out_rdy, hold strictly while stalled; flush
    // empties every slot regardless of out_rdy or a pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_p1[p] <= '0;
                idx_p1[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sel_bus.flush) begin
                    vld_p1[p] <= 1'b0;
                end else if (sel_vld_p0[p]) begin
                    vld_p1[p] <= 1'b1;
                    pkt_p1[p] <= ent_pkt_p0[sel_idx_p0[p]];
                    idx_p1[p] <= sel_idx_p0[p];
                end else if (sel_bus.out_rdy[p]) begin
                    vld_p1[p] <= 1'b0;
                end
            end
        end
    end

    assign sel_bus.out_vld = vld_p1;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out_flat
        assign sel_bus.out_pkt_flat[p*PKT_WIDTH +: PKT_WIDTH] = pkt_p1[p];
        assign sel_bus.out_idx_flat[p*IDX_BITS +: IDX_BITS]   = idx_p1[p];
    end

`ifdef ISSUE_SEL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] issue_cnt_p1 [NUM_PORTS];
    logic [CNT_WIDTH-1:0] stall_cnt_p1 [NUM_PORTS];

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Issue counts slot loads; stall counts cycles a valid slot is refused.
    // Flush does not clear the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                issue_cnt_p1[p] <= '0;
                stall_cnt_p1[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sel_vld_p0[p]) begin
                    issue_cnt_p1[p] <= sat_inc(issue_cnt_p1[p]);
                end
                if (vld_p1[p] && !sel_bus.out_rdy[p]) begin
                    stall_cnt_p1[p] <= sat_inc(stall_cnt_p1[p]);
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf_flat
        assign sel_bus.perf_issue_cnt_flat[p*CNT_WIDTH +: CNT_WIDTH] = issue_cnt_p1[p];
        assign sel_bus.perf_stall_cnt_flat[p*CNT_WIDTH +: CNT_WIDTH] = stall_cnt_p1[p];
    end
`endif

endmodule

// File: tb/tb_isq_issue_sel.sv
// tb_isq_issue_sel: directed scenarios plus randomized traffic for
// isq_issue_sel, checked against an age-ordered behavioural model.
module tb_isq_issue_sel;
    localparam int D    = 64;
    localparam int IB   = 6;
    localparam int PW   = 66;
    localparam int NP   = 4;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    isq_issue_sel_if #(.ISQ_DEPTH(D), .IDX_BITS(IB), .PKT_WIDTH(PW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) isq_bus();

    isq_issue_sel #(.ISQ_DEPTH(D), .IDX_BITS(IB), .PKT_WIDTH(PW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel_bus (isq_bus)
    );

    // ISQ / execute stimulus state
    logic [D-1:0]    q_vld, q_wat, q_rdy;
    logic [D*NP-1:0] q_msk;
    logic [D*PW-1:0] q_pkt;
    logic [IB-1:0]   q_head;
    logic            q_flush;
    logic [NP-1:0]   q_ordy;

    assign isq_bus.isq_vld           = q_vld;
    assign isq_bus.isq_wat           = q_wat;
    assign isq_bus.isq_rdy           = q_rdy;
    assign isq_bus.isq_port_msk_flat = q_msk;
    assign isq_bus.isq_pkt_flat      = q_pkt;
    assign isq_bus.isq_head          = q_head;
    assign isq_bus.flush             = q_flush;
    assign isq_bus.out_rdy           = q_ordy;

    // Reference model state: expected slots, counters, and this cycle's picks
    bit            e_vld [NP];
    logic [IB-1:0] e_idx [NP];
    logic [PW-1:0] e_pkt [NP];
    int            e_icnt[NP];
    int            e_scnt[NP];
    bit            x_sv  [NP];
    int            x_si  [NP];
    logic [D-1:0]  x_clr;
    logic [D-1:0]  last_clr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IB-1:0] port_idx(input int p);
        return isq_bus.out_idx_flat[p*IB +: IB];
    endfunction

    function automatic logic [PW-1:0] port_pkt(input int p);
        return isq_bus.out_pkt_flat[p*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[PW-1:0];
    endfunction

    task automatic set_ent(input int i, input logic [NP-1:0] m);
        q_vld[i] = 1'b1;
        q_wat[i] = 1'b1;
        q_rdy[i] = 1'b1;
        q_msk[i*NP +: NP] = m;
        q_pkt[i*PW +: PW] = rand_pkt();
    endtask

    task automatic clear_isq();
        q_vld = '0;
        q_wat = '0;
        q_rdy = '0;
        q_msk = '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            e_vld[p] = 1'b0; e_idx[p] = '0; e_pkt[p] = '0;
            e_icnt[p] = 0;   e_scnt[p] = 0;
        end
    endtask

    // For each free port in order, the eligible unclaimed entry of least age
    task automatic model_pick();
        x_clr = '0;
        for (int p = 0; p < NP; p++) begin
            int best;
            int best_age;
            x_sv[p] = 1'b0;
            x_si[p] = 0;
            best = -1;
            best_age = D;
            if (!(rst || q_flush || (e_vld[p] && !q_ordy[p]))) begin
                for (int i = 0; i < D; i++) begin
                    int age;
                    age = (i - int'(q_head) + D) % D;
                    if (q_vld[i] && q_wat[i] && q_rdy[i] && q_msk[i*NP + p] && !x_clr[i] && age < best_age) begin
                        best = i;
                        best_age = age;
                    end
                end
            end
            if (best >= 0) begin
                x_sv[p] = 1'b1;
                x_si[p] = best;
                x_clr[best] = 1'b1;
            end
        end
    endtask

    // Clock-edge effects on the expected slots, counters and ISQ wait bits
    task automatic model_edge();
        for (int p = 0; p < NP; p++) begin
            if (e_vld[p] && !q_ordy[p] && e_scnt[p] < CMAX) e_scnt[p]++;
            if (x_sv[p] && e_icnt[p] < CMAX) e_icnt[p]++;
            if (q_flush) begin
                e_vld[p] = 1'b0;
            end else if (x_sv[p]) begin
                e_vld[p] = 1'b1;
                e_idx[p] = IB'(x_si[p]);
                e_pkt[p] = q_pkt[x_si[p]*PW +: PW];
            end else if (q_ordy[p]) begin
                e_vld[p] = 1'b0;
            end
        end
        for (int i = 0; i < D; i++) begin
            if (x_clr[i]) q_wat[i] = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s_vld%0d", tag, p), 128'(isq_bus.out_vld[p]), 128'(e_vld[p]));
            chk($sformatf("%s_idx%0d", tag, p), 128'(port_idx(p)), 128'(e_idx[p]));
            chk($sformatf("%s_pkt%0d", tag, p), 128'(port_pkt(p)), 128'(e_pkt[p]));
`ifdef ISSUE_SEL_PERF_CNT_EN
            chk($sformatf("%s_icnt%0d", tag, p), 128'(isq_bus.perf_issue_cnt_flat[p*CW +: CW]), 128'(e_icnt[p]));
            chk($sformatf("%s_scnt%0d", tag, p), 128'(isq_bus.perf_stall_cnt_flat[p*CW +: CW]), 128'(e_scnt[p]));
`endif
        end
    endtask

    // One clock: check the combinational picks, then the registered slots
    task automatic cycle(input string tag);
        #1;
        model_pick();
        last_clr = isq_bus.sel_clr_wat;
        chk({tag, "_clr"}, 128'(last_clr), 128'(x_clr));
        @(posedge clk);
        #1;
        model_edge();
        check_outs(tag);
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < D; i++) begin
            if ((!q_vld[i] || !q_wat[i]) && $urandom_range(0, 3) == 0) begin
                set_ent(i, NP'($urandom_range(1, (1 << NP) - 1)));
                q_rdy[i] = ($urandom_range(0, 1) == 1);
            end else if (q_vld[i] && !q_wat[i] && $urandom_range(0, 3) == 0) begin
                q_vld[i] = 1'b0;
            end else if (q_wat[i] && $urandom_range(0, 15) == 0) begin
                q_vld[i] = ~q_vld[i];
            end else if ($urandom_range(0, 2) == 0) begin
                q_rdy[i] = ~q_rdy[i];
            end
        end
        if ($urandom_range(0, 3) == 0) q_head = IB'($urandom_range(0, D - 1));
        for (int p = 0; p < NP; p++) q_ordy[p] = ($urandom_range(0, 3) != 0);
        q_flush = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        clear_isq();
        q_pkt = '0; q_head = '0; q_flush = 1'b0; q_ordy = '1;
        model_reset();

        // Reset state, and no selection while reset is held
        #2;
        check_outs("rst");
        set_ent(3, 4'b1111);
        #1;
        chk("rst_clr", 128'(isq_bus.sel_clr_wat), 128'(0));
        clear_isq();
        @(negedge clk);
        rst = 1'b0;

        // Oldest-first on port 1, wait cleared between picks
        set_ent(3, 4'b0010); set_ent(5, 4'b0010); set_ent(9, 4'b0010);
        cycle("t1a");
        chk("t1a_idx1", 128'(port_idx(1)), 128'(3));
        chk("t1a_clrv", 128'(last_clr), 128'(64'h8));
        cycle("t1b");
        chk("t1b_idx1", 128'(port_idx(1)), 128'(5));
        chk("t1b_clrv", 128'(last_clr), 128'(64'h20));

        // Wrap-around from head=62
        clear_isq();
        q_head = 6'd62;
        set_ent(1, 4'b0110); set_ent(63, 4'b0110);
        cycle("t2");
        chk("t2_idx1", 128'(port_idx(1)), 128'(63));
        chk("t2_idx2", 128'(port_idx(2)), 128'(1));
        chk("t2_clrv", 128'(last_clr), 128'(64'h8000_0000_0000_0002));

        // Back-pressure hold on port 0
        clear_isq();
        q_head = '0;
        set_ent(7, 4'b0001);
        cycle("t3l");
        chk("t3l_idx0", 128'(port_idx(0)), 128'(7));
        set_ent(8, 4'b0001);
        q_ordy = 4'b1110;
        repeat (3) begin
            cycle("t3h");
            chk("t3h_idx0", 128'(port_idx(0)), 128'(7));
            chk("t3h_pkt0", 128'(port_pkt(0)), 128'(q_pkt[7*PW +: PW]));
            chk("t3h_clrv", 128'(last_clr), 128'(0));
        end
        q_ordy = '1;
        cycle("t3r");
        chk("t3r_clrv", 128'(last_clr), 128'(64'h100));
        chk("t3r_idx0", 128'(port_idx(0)), 128'(8));

        // Flush beats out_rdy and pending loads
        clear_isq();
        for (int i = 10; i < 14; i++) set_ent(i, 4'b1111);
        cycle("t4l");
        chk("t4l_vld", 128'(isq_bus.out_vld), 128'(4'hF));
        for (int i = 20; i < 24; i++) set_ent(i, 4'b1111);
        q_flush = 1'b1;
        q_ordy = 4'b0101;
        cycle("t4f");
        chk("t4f_clrv", 128'(last_clr), 128'(0));
        chk("t4f_vld", 128'(isq_bus.out_vld), 128'(0));
        q_flush = 1'b0;
        q_ordy = '1;
        cycle("t4r");
        chk("t4r_clrv", 128'(last_clr), 128'(64'h00F0_0000));
        chk("t4r_vld", 128'(isq_bus.out_vld), 128'(4'hF));

        // Asynchronous reset mid-cycle while all ports hold packets
        q_ordy = '0;
        clear_isq();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_vld", 128'(isq_bus.out_vld), 128'(0));
        chk("t5_async_idx3", 128'(port_idx(3)), 128'(0));
        model_reset();
        check_outs("t5");
        @(negedge clk);
        rst = 1'b0;
        q_ordy = '1;
        cycle("t5p");
        cycle("t5p");
        chk("t5p_vld", 128'(isq_bus.out_vld), 128'(0));

        // Port 3: five issues, then two stalled cycles
        for (int k = 0; k < 5; k++) begin
            set_ent(30 + k, 4'b1000);
            cycle("t6i");
        end
        q_ordy = 4'b0111;
        cycle("t6s");
        cycle("t6s");
        chk("t6_vld3", 128'(isq_bus.out_vld[3]), 128'(1));
        chk("t6_idx3", 128'(port_idx(3)), 128'(34));
`ifdef ISSUE_SEL_PERF_CNT_EN
        chk("t6_icnt3", 128'(isq_bus.perf_issue_cnt_flat[3*CW +: CW]), 128'(5));
        chk("t6_scnt3", 128'(isq_bus.perf_stall_cnt_flat[3*CW +: CW]), 128'(2));
`endif

        // Randomized traffic
        q_ordy = '1;
        repeat (400) begin
            rand_inputs();
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/isq_issue_sel.md
Name: isq_issue_sel

Overview:
- Parametrised issue-select stage between the issue queue (ISQ) and the register-file read stage.
- Each cycle it picks, for each of NUM_PORTS function-unit ports, the oldest ready and eligible ISQ entry. Age is measured from a rotating head pointer, not from fixed index 0.
- Each pick is registered into a per-port output slot with a valid/ready handshake toward execute.
- Successor of the fixed 4-port priority decoder: port count, depth and packet width are parametrised, selection is age-ordered, and back-pressure and flush are supported.

Parameters:
- ISQ_DEPTH, 64, number of ISQ entries.
- IDX_BITS, 6, width of the entry index; must equal clog2(ISQ_DEPTH).
- PKT_WIDTH, 66, width of the issue packet per entry; the packet is already in issue-stage format.
- NUM_PORTS, 4, number of function-unit ports.
- CNT_WIDTH, 16, width of each perf counter (optional feature only).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- isq_pkt_flat, input, ISQ_DEPTH*PKT_WIDTH, packet of entry i at bits [PKT_WIDTH*(i+1)-1 : PKT_WIDTH*i].
- isq_vld, input, ISQ_DEPTH, entry valid.
- isq_wat, input, ISQ_DEPTH, entry is still waiting to issue.
- isq_rdy, input, ISQ_DEPTH, entry operands are ready.
- isq_port_msk_flat, input, ISQ_DEPTH*NUM_PORTS, bit (i*NUM_PORTS+p) set means entry i may issue on port p.
- isq_head, input, IDX_BITS, index of the oldest entry.
- flush, input, 1, pipeline flush.
- out_rdy, input, NUM_PORTS, execute-side port p accepts its packet this cycle.
- out_vld, output, NUM_PORTS, port p holds a valid packet.
- out_pkt_flat, output, NUM_PORTS*PKT_WIDTH, registered packet per port.
- out_idx_flat, output, NUM_PORTS*IDX_BITS, ISQ index of each registered packet.
- sel_clr_wat, output, ISQ_DEPTH, one-hot-per-port OR of the entries selected this cycle; combinational.

Behaviour:
- Reset: all out_vld=0, out_pkt=0, out_idx=0; perf counters=0. sel_clr_wat is 0 during reset because selection is gated by rst.
- An entry is eligible when isq_vld & isq_wat & isq_rdy are all set and flush=0.
- A port is free when out_vld[p]=0 or out_rdy[p]=1 (the slot drains this cycle).
- Selection order:
  - Ports are served sequentially, port 0 first.
  - For port p, search entries in age order: head, head+1, ..., wrapping modulo ISQ_DEPTH, ending at head-1.
  - Pick the first entry that is eligible, has mask bit p set, and was not taken by a lower-numbered port this cycle.
  - A busy port (not free) selects nothing and does not block higher ports.
- On a selection for port p:
  - At the next edge, load out_pkt/out_idx for p and set out_vld[p]=1.
  - sel_clr_wat[idx]=1 in the same cycle. The ISQ clears wat at that same edge, so the entry cannot be picked twice.
- Port free but no candidate: if out_rdy[p]=1, clear out_vld[p] at the edge. Otherwise the slot is already empty and stays empty.
- Port busy (out_vld=1, out_rdy=0): packet and idx hold stable. This is a strict hold; the values must not change.
- Latency: an entry that is eligible in cycle N appears at the outputs in cycle N+1. Throughput is one packet per port per cycle.
- Flush:
  - Suppresses all selection in the current cycle, so sel_clr_wat=0.
  - At the next edge clears every out_vld, whatever the state of out_rdy.
  - Flush has priority over a simultaneous out_rdy or a pending load.
- Wrap-around: with head=ISQ_DEPTH-1, entry ISQ_DEPTH-1 is oldest, followed by entry 0.
- No eligible entries anywhere: all sel_clr_wat=0 and no slot is loaded.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); any in-flight packet is lost.

Optional Feature:
- Macro ISSUE_SEL_PERF_CNT_EN.
- Defined:
  - Adds output perf_issue_cnt_flat, NUM_PORTS*CNT_WIDTH.
  - Adds output perf_stall_cnt_flat, NUM_PORTS*CNT_WIDTH.
  - Per port, the issue count increments on each load. The stall count increments each cycle that out_vld=1 and out_rdy=0.
  - Both counters saturate at all-ones, reset to 0, and are not cleared by flush.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Setup: head=0; entries 3, 5 and 9 eligible with mask=4'b0010; all out_rdy=1.
   - Cycle 1: port1 takes idx 3, sel_clr_wat=bit3.
   - Cycle 2 (entry 3 wat cleared): port1 takes idx 5.
2. Setup: head=62; entries 1 and 63 eligible with mask=4'b0110.
   - Port1 takes idx 63 and port2 takes idx 1 in the same cycle.
   - sel_clr_wat has bits 63 and 1 set.
3. Setup: port0 loaded with idx 7, out_rdy[0]=0 for 3 cycles; entry 8 eligible with mask 4'b0001.
   - out_pkt[0] and out_idx[0] stay at entry 7 for 3 cycles, and entry 8 is not cleared.
   - The cycle out_rdy[0]=1 rises, entry 8 is selected; it is visible at the outputs the following cycle.
4. Setup: flush=1 while all ports are valid and 4 entries are eligible.
   - sel_clr_wat=0 that cycle; all out_vld=0 next cycle.
   - Selection resumes the cycle after flush drops.
5. Setup: rst asserted asynchronously mid-cycle while ports are valid.
   - out_vld clears immediately, without waiting for a clock edge.
   - After release, with no eligible entries, outputs stay 0.
6. Setup: ISSUE_SEL_PERF_CNT_EN defined; port3 issues 5 packets and is stalled for 2 cycles.
   - perf_issue_cnt[3]=5 and perf_stall_cnt[3]=2.
   - With CNT_WIDTH=2, the issue count saturates at 3.
